// File: rtl/dpdm_encode.sv
// USB full-speed transmit line encoder.
// Takes an un-stuffed payload bit stream over a valid/ready handshake. Sends
// SYNC, then the payload with bit stuffing and NRZI coding, one symbol per bit
// clock. Ends with SE0, SE0, J and releases the bus.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | bus released (J, en=0); waits for send_start
// SYNC  | emitting SYNC symbols 1..7 (symbol 0 is launched from IDLE)
// DATA  | accepting payload bits, inserting stuff toggles after six ones
// STUFF | stuff toggle after a payload that ends on a run of six ones
// EOP0  | first SE0 of a normal end of packet
// EOP1  | second SE0 (the abort path enters here)
// EOP2  | final J with the bus still driven, then back to IDLE

module dpdm_encode (
   input  logic clock,
   input  logic reset_n,
   input  logic send_start,
   input  logic bit_in,
   input  logic bit_valid,
   input  logic bit_last,
   output logic bit_ready,
   output logic DP_out,
   output logic DM_out,
   output logic dpdm_en,
   output logic tx_busy,
   output logic tx_done,
   output logic tx_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_DATA,
      S_STUFF,
      S_EOP0,
      S_EOP1,
      S_EOP2
   } state_t;

   state_t     state, state_nx;
   logic [2:0] sync_cnt, sync_cnt_nx;
   logic [2:0] ones, ones_nx;
   logic       lvl, lvl_nx;          // current NRZI level, 1 = J
   logic       aborted, aborted_nx;  // suppresses tx_done after an underrun
   logic       dp_nx, dm_nx, en_nx, done_nx, err_nx;

   assign tx_busy = (state != S_IDLE);

   // State, line and pulse registers; reset parks the bus at J, undriven.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         sync_cnt <= 3'd0;
         ones     <= 3'd0;
         lvl      <= 1'b1;
         aborted  <= 1'b0;
         DP_out   <= 1'b1;
         DM_out   <= 1'b0;
         dpdm_en  <= 1'b0;
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
      end else begin
         state    <= state_nx;
         sync_cnt <= sync_cnt_nx;
         ones     <= ones_nx;
         lvl      <= lvl_nx;
         aborted  <= aborted_nx;
         DP_out   <= dp_nx;
         DM_out   <= dm_nx;
         dpdm_en  <= en_nx;
         tx_done  <= done_nx;
         tx_error <= err_nx;
      end
   end

   // Next state, next line symbol and the payload handshake.
   always_comb begin
      state_nx    = state;
      sync_cnt_nx = sync_cnt;
      ones_nx     = ones;
      lvl_nx      = lvl;
      aborted_nx  = aborted;
      dp_nx       = DP_out;
      dm_nx       = DM_out;
      en_nx       = dpdm_en;
      done_nx     = 1'b0;
      err_nx      = 1'b0;
      bit_ready   = 1'b0;

      case (state)
         S_IDLE: begin
            dp_nx  = 1'b1;
            dm_nx  = 1'b0;
            en_nx  = 1'b0;
            lvl_nx = 1'b1;
            if (send_start) begin
               // First SYNC bit is a raw 0: toggle from J to K.
               lvl_nx      = 1'b0;
               dp_nx       = 1'b0;
               dm_nx       = 1'b1;
               en_nx       = 1'b1;
               sync_cnt_nx = 3'd1;
               ones_nx     = 3'd0;
               aborted_nx  = 1'b0;
               state_nx    = S_SYNC;
            end
         end

         S_SYNC: begin
            // SYNC raw bits are 0000_0001; only the last one holds the level.
            if (sync_cnt == 3'd7) begin
               ones_nx  = 3'd1;
               state_nx = S_DATA;
            end else begin
               lvl_nx = ~lvl;
            end
            dp_nx       = lvl_nx;
            dm_nx       = ~lvl_nx;
            sync_cnt_nx = sync_cnt + 3'd1;
         end

         S_DATA: begin
            if (ones == 3'd6) begin
               lvl_nx  = ~lvl;
               ones_nx = 3'd0;
               dp_nx   = lvl_nx;
               dm_nx   = ~lvl_nx;
            end else begin
               bit_ready = 1'b1;
               if (bit_valid) begin
                  if (bit_in) begin
                     ones_nx = ones + 3'd1;
                  end else begin
                     lvl_nx  = ~lvl;
                     ones_nx = 3'd0;
                  end
                  dp_nx = lvl_nx;
                  dm_nx = ~lvl_nx;
                  if (bit_last) begin
                     state_nx = (bit_in && ones == 3'd5) ? S_STUFF : S_EOP0;
                  end
               end else begin
                  // Underrun: first SE0 now, then join the normal EOP tail.
                  dp_nx      = 1'b0;
                  dm_nx      = 1'b0;
                  err_nx     = 1'b1;
                  aborted_nx = 1'b1;
                  state_nx   = S_EOP1;
               end
            end
         end

         S_STUFF: begin
            lvl_nx   = ~lvl;
            ones_nx  = 3'd0;
            dp_nx    = lvl_nx;
            dm_nx    = ~lvl_nx;
            state_nx = S_EOP0;
         end

         S_EOP0: begin
            dp_nx    = 1'b0;
            dm_nx    = 1'b0;
            state_nx = S_EOP1;
         end

         S_EOP1: begin
            dp_nx    = 1'b0;
            dm_nx    = 1'b0;
            state_nx = S_EOP2;
         end

         S_EOP2: begin
            dp_nx    = 1'b1;
            dm_nx    = 1'b0;
            en_nx    = 1'b1;
            done_nx  = ~aborted;
            state_nx = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: doc/dpdm_encode.md
# dpdm_encode

Transmit-side line encoder for the USB full-speed serial path, and the counterpart of the receive-side DP/DM decoder. It accepts a raw, un-stuffed bit stream through a valid/ready handshake. It prepends SYNC, applies bit stuffing and NRZI encoding, and drives DP/DM one symbol per clock (clock = bit clock). It then appends the EOP (SE0, SE0, J) and releases the bus.

## Interface
- No parameters.
- clock  in  1  bit clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- send_start  in  1  single-cycle request to begin a packet; honoured only in IDLE.
- bit_in  in  1  payload bit, LSB-first order supplied by upstream.
- bit_valid  in  1  bit_in is valid.
- bit_last  in  1  qualifies bit_in as the final payload bit.
- bit_ready  out  1  combinational; payload bit is accepted on an edge where bit_valid & bit_ready.
- DP_out  out  1  registered D+ level.
- DM_out  out  1  registered D- level.
- dpdm_en  out  1  registered bus drive enable.
- tx_busy  out  1  high in every state except IDLE.
- tx_done  out  1  registered one-cycle pulse at the end of a normal packet.
- tx_error  out  1  registered one-cycle pulse when a packet is aborted on underrun.

## Operation
- Line symbols: J = DP 1/DM 0; K = DP 0/DM 1; SE0 = 0/0. When dpdm_en=0, DP/DM are J.
- NRZI: a 0 toggles the line level (J↔K); a 1 holds it.
- SYNC: K J K J K J K K (raw 0000_0001). After SYNC, the NRZI level is K and the ones counter is 1.
- Stuffing:
  - 3-bit ones counter: +1 on each transmitted 1; cleared on each 0 or stuff bit.
  - When the counter reaches 6, the next symbol is a stuff bit: an NRZI toggle, with the counter cleared.
- States:
  - IDLE: en=0, J, bit_ready=0. If send_start: register the first K, en=1, sync_cnt=1, go to SYNC.
  - SYNC: register symbol sync_cnt (1..7); sync_cnt++. At sync_cnt==7, go to DATA with ones=1.
  - DATA, ones<6: bit_ready=1.
    - valid: register NRZI(bit_in). If bit_last: go to STUFF when the counter becomes 6, otherwise to EOP0.
    - !valid: underrun. Register SE0, pulse tx_error, go to EOP1.
  - DATA, ones==6: bit_ready=0. Register the stuff toggle, clear ones, stay in DATA.
  - STUFF: register the stuff toggle, go to EOP0. This stuffs a trailing run of six ones.
  - EOP0: register SE0 → EOP1.
  - EOP1: register SE0 → EOP2.
  - EOP2: register J with en=1, pulse tx_done (skipped on the abort path; tx_error already pulsed), go to IDLE. The next cycle registers en=0.
- send_start outside IDLE is ignored.
- bit_last is ignored unless accepted.
- bit_ready is never high outside DATA.

## Timing
- Reset (asynchronous, immediate), including mid-packet:
  - state IDLE, DP_out=1, DM_out=0, dpdm_en=0;
  - tx_busy=0, tx_done=0, tx_error=0, bit_ready=0;
  - counters cleared, NRZI level J.
  - No EOP is emitted for the interrupted packet.
- Latency:
  - send_start sampled at edge E0 puts the first SYNC K on the line after E0.
  - The last SYNC K appears after E7.
  - bit_ready is first high in the cycle following E7.
- An accepted payload bit appears on DP/DM after the accepting edge (1-cycle latency).
- Upstream must hold bit_valid high throughout DATA. A single low cycle while bit_ready=1 aborts the packet.
- Packet length on the bus = 8 (SYNC) + N payload + S stuff + 3 EOP cycles, then dpdm_en drops.
- tx_done is high in the same cycle as the EOP J symbol.
- tx_error is high in the same cycle as the first abort SE0.

## Test plan
- Reset idle: hold reset_n=0, release, wait 10 cycles → DP=1, DM=0, dpdm_en=0, tx_busy=0, bit_ready=0.
- ACK packet, bits 0,1,0,0,1,0,1,1 with bit_last on the 8th:
  - line = KJKJKJKK, JJKJJKKK, SE0, SE0, J; then en=0.
  - tx_done pulses exactly once, with the J symbol.
- Stuffing, 8 ones (last on the 8th):
  - line after SYNC = K×5, J (stuff), J×3, SE0, SE0, J.
  - bit_ready is low for exactly the one cycle after the 5th acceptance.
- Trailing stuff: payload of 5 ones with bit_last on the 5th → K×5, J (STUFF), SE0, SE0, J.
- Underrun: drop bit_valid for one cycle after 3 bits → SE0, SE0 on the line, tx_error=1 with the first SE0, no tx_done, return to IDLE.
- Reset mid-DATA, plus send_start issued during EOP1:
  - reset → DP/DM=J and en=0 immediately, no EOP.
  - send_start during EOP1 is ignored; tx_busy falls once and no second SYNC follows.
